// File: rtl/bcd_seg_scanner.sv
// Multiplexed 7-segment scanner for packed BCD values.
// One digit position is lit per time slot. A new value is only taken at the
// frame boundary, so a frame never shows a mix of two values. Leading zeros
// can be blanked, and each slot starts with a dark guard interval to avoid
// ghosting. A one-cycle frame_done pulse marks each scan wrap.
module bcd_seg_scanner #(
  parameter int NDECS          = 3,
  parameter int CLK_DIV        = 1000,
  parameter int GUARD          = 2,
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NDECS*4-1:0] decimal,
  input  logic               load,
  output logic [6:0]         segments,
  output logic [NDECS-1:0]   digit_en,
  output logic               frame_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NDECS > 1) ? $clog2(NDECS) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0]    IDX_LAST = IW'(NDECS - 1);
  localparam logic [CW-1:0]    GUARD_C  = CW'(GUARD);
  localparam logic [6:0]       SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NDECS-1:0] DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? {NDECS{1'b1}} : {NDECS{1'b0}};

  // Reject parameter sets the scan timing cannot honour.
  generate
    if (GUARD >= CLK_DIV || GUARD < 0 || CLK_DIV < 2 || NDECS < 1) begin : g_bad_params
      $error("bcd_seg_scanner: need NDECS>=1, CLK_DIV>=2 and 0<=GUARD<CLK_DIV");
    end
  endgenerate

  logic [NDECS*4-1:0] pending_reg, pending_next;
  logic [NDECS*4-1:0] display_reg, display_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [IW-1:0]      index_reg, index_next;
  logic [6:0]         seg_reg, seg_next;
  logic [NDECS-1:0]   en_reg, en_next;
  logic               frame_done_reg, frame_done_next;

  logic               tick;
  logic               wrap;
  logic               in_guard;
  logic               show;
  logic [3:0]         cur_digit;
  logic [6:0]         seg_on;
  logic [NDECS-1:0]   en_on;

  // Per-position digit value and "may be lit" flag (false only for a leading zero).
  logic [3:0]       digit_val [NDECS];
  logic [NDECS-1:0] lit_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NDECS; gi++) begin : g_digit
      assign digit_val[gi] = display_reg[gi*4 +: 4];
      if (gi == 0 || BLANK_LZ == 0) begin : g_keep
        assign lit_ok[gi] = 1'b1;
      end else begin : g_lz
        // Lit if this digit or any more significant one is non-zero.
        assign lit_ok[gi] = |display_reg[NDECS*4-1:gi*4];
      end
    end
  endgenerate

  // BCD to segment pattern {g,f,e,d,c,b,a}, active-high; non-decimal codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000;
    endcase
  endfunction

  // Next-state: prescaler, scan index, capture/commit of values, and output patterns.
  always_comb begin
    tick            = (cnt_reg == CNT_LAST);
    wrap            = tick && (index_reg == IDX_LAST);
    in_guard        = (GUARD > 0) && (cnt_reg < GUARD_C);
    cur_digit       = digit_val[index_reg];
    show            = !in_guard && lit_ok[index_reg];
    seg_on          = decode(cur_digit);
    en_on           = NDECS'(1) << index_reg;

    pending_next    = load ? decimal : pending_reg;
    display_next    = display_reg;
    cnt_next        = tick ? '0 : cnt_reg + 1'b1;
    index_next      = index_reg;
    frame_done_next = wrap;

    if (tick) begin
      index_next = (index_reg == IDX_LAST) ? '0 : index_reg + 1'b1;
    end
    // A load on the boundary cycle itself goes straight to the display.
    if (wrap) begin
      display_next = load ? decimal : pending_reg;
    end

    seg_next = (show ? seg_on : 7'h00) ^ SEG_OFF;
    en_next  = (show ? en_on : {NDECS{1'b0}}) ^ DIG_OFF;
  end

  // State and output registers, synchronous reset to a dark display.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_reg    <= '0;
      display_reg    <= '0;
      cnt_reg        <= '0;
      index_reg      <= '0;
      seg_reg        <= SEG_OFF;
      en_reg         <= DIG_OFF;
      frame_done_reg <= 1'b0;
    end else begin
      pending_reg    <= pending_next;
      display_reg    <= display_next;
      cnt_reg        <= cnt_next;
      index_reg      <= index_next;
      seg_reg        <= seg_next;
      en_reg         <= en_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign segments   = seg_reg;
  assign digit_en   = en_reg;
  assign frame_done = frame_done_reg;

endmodule
